// File: rtl/pwm_spi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pwm_spi_pkg
// Purpose  : Shared constants and types for the PWM SPI configuration slave:
//            register addresses, frame length and the frame-state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package pwm_spi_pkg;

    // Register map
    localparam logic [6:0] ADDR_EN_OUT_LO = 7'h00;
    localparam logic [6:0] ADDR_EN_OUT_HI = 7'h01;
    localparam logic [6:0] ADDR_EN_PWM_LO = 7'h02;
    localparam logic [6:0] ADDR_EN_PWM_HI = 7'h03;
    localparam logic [6:0] ADDR_DUTY      = 7'h04;

    // Frame geometry and bit counter
    localparam int               FRAME_BITS = 16;
    localparam int               CNT_W      = 5;
    localparam logic [CNT_W-1:0] CNT_SAT    = 5'd17;

    // IDLE while nCS is high, SHIFT while a frame is being received
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } spi_state_t;

endpackage
`default_nettype wire

// File: rtl/spi_sync_edge.sv
`default_nettype none
// ============================================================================
// Module   : spi_sync_edge
// Purpose  : Multi-flop synchronizer for one asynchronous SPI pin, followed
//            by a history flop so rising/falling edges can be detected.
// Revision : 1.0 - initial release
// ============================================================================
module spi_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_hist;

    // Resample the pin through the chain and remember the previous level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= {SYNC_STAGES{RESET_VAL}};
            r_hist <= RESET_VAL;
        end else begin
            r_sync[0] <= i_async;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_hist <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_level = r_sync[SYNC_STAGES-1];
    assign o_rise  =  o_level & ~r_hist;
    assign o_fall  = ~o_level &  r_hist;

endmodule
`default_nettype wire

// File: rtl/pwm_spi_config.sv
`default_nettype none
// ============================================================================
// Module   : pwm_spi_config
// Purpose  : SPI (mode 0) write-only slave holding the five PWM peripheral
//            configuration registers. 16-bit frames: {rw, addr[6:0], data}.
// Revision : 1.0 - initial release
// ============================================================================
module pwm_spi_config
    import pwm_spi_pkg::*;
#(
    parameter int NUM_REGS    = 5,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk,
    input  logic       copi,
    input  logic       ncs,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle,
    output logic       wr_strobe,
    output logic       frame_err
);

    logic w_sclk_level, w_sclk_rise, w_sclk_fall;
    logic w_copi_level, w_copi_rise, w_copi_fall;
    logic w_ncs_level,  w_ncs_rise,  w_ncs_fall;
    logic w_unused;

    spi_state_t           r_state;
    spi_state_t           w_state_next;
    logic                 w_clear;
    logic                 w_shift_en;
    logic                 w_eval;
    logic [15:0]          r_shift;
    logic [CNT_W-1:0]     r_cnt;
    logic                 w_frame_ok;
    logic                 w_addr_ok;
    logic                 r_wr_pend;
    logic                 r_err_pend;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst(rst), .i_async(sclk),
        .o_level(w_sclk_level), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_copi (
        .clk(clk), .rst(rst), .i_async(copi),
        .o_level(w_copi_level), .o_rise(w_copi_rise), .o_fall(w_copi_fall)
    );

    // nCS resets high so a frame still in progress after reset is seen as a new start
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ncs (
        .clk(clk), .rst(rst), .i_async(ncs),
        .o_level(w_ncs_level), .o_rise(w_ncs_rise), .o_fall(w_ncs_fall)
    );

    // Mode 0 only samples on SCLK rise; the other detector outputs are not needed
    assign w_unused = &{1'b0, w_sclk_level, w_sclk_fall, w_copi_rise, w_copi_fall, w_ncs_level};

    // Frame state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and per-cycle actions; an nCS edge wins over a coincident SCLK edge
    always_comb begin
        w_state_next = r_state;
        w_clear      = 1'b0;
        w_shift_en   = 1'b0;
        w_eval       = 1'b0;
        if (w_ncs_fall) begin
            w_state_next = SHIFT;
            w_clear      = 1'b1;
        end else if (w_ncs_rise) begin
            if (r_state == SHIFT) begin
                w_state_next = IDLE;
                w_eval       = 1'b1;
            end
        end else if ((r_state == SHIFT) && w_sclk_rise) begin
            w_shift_en = 1'b1;
        end
    end

    // Shift register (MSB first, enters at LSB) and saturating bit counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (w_clear) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (w_shift_en) begin
            r_shift <= {r_shift[14:0], w_copi_level};
            if (r_cnt != CNT_SAT) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign w_frame_ok = (r_cnt == CNT_W'(FRAME_BITS));
    assign w_addr_ok  = ({25'd0, r_shift[14:8]} < 32'(NUM_REGS));

    // Classify the finished frame; the shift register stays stable while idle,
    // so the commit one cycle later can still read address and data from it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_pend  <= 1'b0;
            r_err_pend <= 1'b0;
        end else begin
            r_wr_pend  <= w_eval & w_frame_ok & r_shift[15] & w_addr_ok;
            r_err_pend <= w_eval & ~w_frame_ok;
        end
    end

    // Register commit and one-cycle status pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_reg_out_7_0  <= 8'h00;
            en_reg_out_15_8 <= 8'h00;
            en_reg_pwm_7_0  <= 8'h00;
            en_reg_pwm_15_8 <= 8'h00;
            pwm_duty_cycle  <= 8'h00;
            wr_strobe       <= 1'b0;
            frame_err       <= 1'b0;
        end else begin
            wr_strobe <= r_wr_pend;
            frame_err <= r_err_pend;
            if (r_wr_pend) begin
                case (r_shift[14:8])
                    ADDR_EN_OUT_LO: en_reg_out_7_0  <= r_shift[7:0];
                    ADDR_EN_OUT_HI: en_reg_out_15_8 <= r_shift[7:0];
                    ADDR_EN_PWM_LO: en_reg_pwm_7_0  <= r_shift[7:0];
                    ADDR_EN_PWM_HI: en_reg_pwm_15_8 <= r_shift[7:0];
                    ADDR_DUTY:      pwm_duty_cycle  <= r_shift[7:0];
                    default: ;
                endcase
            end
        end
    end

endmodule
`default_nettype wire
